pll_lock_monitor: RTL and testbench
===================================

# pll_lock_monitor

Qualifies the raw lock indications from the house-keeping FF PLL (`pll_lo`/`pll_hi` comparator outputs plus the reference-valid flag). It integrates them over fixed windows and produces a debounced lock status, a lock-change event, per-window duty measurements and a loss-of-lock counter. It sits directly downstream of the house-keeping PLL logic, and its status outputs are read back over the house-keeping register bus.

## Interface
Parameters:
- `WIN`, 125000: window length in `clk_i` cycles (1 ms at 125 MHz); must be ≥ 16.
- `THR`, 87500: per-window count threshold, 70 % of `WIN`; must be < `WIN`.
- `LOCK_WINS`, 4: consecutive good windows required to declare lock, 1..15.
- `UNLOCK_WINS`, 2: consecutive bad windows required to declare loss of lock, 1..15.

Ports:
- `clk_i` in 1: system clock.
- `pll_ff_rst` in 1: reset, asynchronous, active-low; clock `clk_i`.
- `pll_lo_i` in 1: FF-PLL low indication, asynchronous; active high.
- `pll_hi_i` in 1: FF-PLL high indication, asynchronous; active low (good when 0).
- `ref_val_i` in 1: reference-frequency-valid flag, `clk_i` domain.
- `en_i` in 1: monitor enable level.
- `clr_i` in 1: single-cycle pulse; clears `unlock_cnt_o` and the irq.
- `lock_o` out 1: debounced lock status.
- `lock_chg_o` out 1: one-cycle pulse on any `lock_o` change.
- `state_o` out 2: FSM state.
- `duty_lo_o` out W: `pll_lo` count latched from the last completed window.
- `duty_hi_o` out W: `pll_hi`-low count latched from the last completed window.
- `unlock_cnt_o` out 16: number of LOCKED→ACQ transitions; saturates at 0xFFFF.
- `irq_o` out 1: sticky lock-change interrupt; present only with the macro enabled.

W = clog2(`WIN`+1).

## Operation
- Both `pll_lo_i` and `pll_hi_i` pass through 2-FF synchronizers. The synchronized values are `lo_s` and `hi_s`.
- Window counter `wcnt` runs 0..`WIN`-1 and wraps. Two accumulators run alongside it:
  - `lo_acc` increments when `lo_s`=1.
  - `hi_acc` increments when `hi_s`=0.
  - Both saturate at `WIN`.
- At `wcnt`=`WIN`-1:
  - `good` = (`lo_acc` > `THR`) && (`hi_acc` > `THR`) && `ref_val_i`. All comparisons are strict and use the accumulator value including the current cycle.
  - `duty_lo_o` and `duty_hi_o` load from the accumulators, and the accumulators restart at 0.
- The run counter `run` (4 bits) counts consecutive windows agreeing with the FSM's target.
- FSM states (`state_o`): IDLE=0, ACQ=1, LOCKED=2, HOLD=3.
  - IDLE: counters held at 0. Leaves to ACQ when `en_i`=1.
  - ACQ: a good window increments `run`; a bad window clears it. When `run` reaches `LOCK_WINS`, go to LOCKED and clear `run`.
  - LOCKED: a bad window goes to HOLD with `run`=1. If `UNLOCK_WINS`=1, go straight to ACQ instead.
  - HOLD: a good window returns to LOCKED and clears `run`. A bad window increments `run`; when it reaches `UNLOCK_WINS`, go to ACQ and clear `run`.
  - Any state with `en_i`=0 goes to IDLE on the next edge.
- `lock_o` = 1 in LOCKED and HOLD.
- `unlock_cnt_o` increments on every exit from {LOCKED, HOLD} to ACQ or IDLE.
- Simultaneous events:
  - `clr_i` coincident with an increment clears the counter (clear wins).
  - `en_i`=0 coincident with a window end: IDLE wins, and `duty_*` still latch.
- A `ref_val_i` drop alone makes the current window bad; there is no immediate unlock.

## Timing
- Reset values: `lock_o`=0, `lock_chg_o`=0, `state_o`=0, `duty_*`=0, `unlock_cnt_o`=0, `irq_o`=0. Reset is applied asynchronously and released synchronously through a 2-FF deassert stage.
- Input-to-accumulator latency is 2 cycles (synchronizer) plus 1 cycle.
- `state_o`, `lock_o` and `duty_*` update on the edge at `wcnt`=`WIN`-1.
- `lock_chg_o` is high for exactly the cycle after that edge.
- Earliest lock after `en_i` rises: `LOCK_WINS`·`WIN` + 1 cycles, provided the first window starts on the edge after `en_i`.
- Reset mid-window discards all partial counts.

## Configuration
- `PLL_LOCK_MON_IRQ_EN` defined:
  - `irq_o` sets on any `lock_chg_o` pulse and clears on `clr_i`.
  - A set on the same cycle as `clr_i` wins.
- Undefined: `irq_o` is tied to 0 and its register is not built.

## Structure
- Package `pll_mon_pkg` holds:
  - the state enum `pll_mon_state_t` (IDLE/ACQ/LOCKED/HOLD);
  - the width constant for `unlock_cnt_o` (16);
  - the run-counter width (4).
- Sub-module `pll_mon_sync`: a 2-FF bit synchronizer with asynchronous reset, instantiated once each for lo and hi.

## Test plan
- `WIN`=100, `THR`=70, `LOCK_WINS`=4; `lo`=1, `hi`=0, `ref_val`=1 constant → `lock_o` rises 401 cycles after `en_i`, with a single `lock_chg_o` pulse and `duty_lo_o`=`duty_hi_o`=100.
- Locked, then `lo` high for only 70 of 100 cycles for 2 windows (`UNLOCK_WINS`=2) → HOLD after window 1, ACQ after window 2; `lock_o` falls; `unlock_cnt_o`=1; `duty_lo_o`=70 (not > `THR`).
- Locked, then one bad window followed by a good one → HOLD then LOCKED; `lock_o` stays 1; no `lock_chg_o`; `unlock_cnt_o` unchanged.
- `ref_val_i`=0 for one cycle in each window with `lo`/`hi` ideal → never locks; `state_o` stays 1.
- `clr_i` on the same cycle as an unlock increment → `unlock_cnt_o`=0. With the macro enabled, `irq_o`=1 afterwards.
- Assert `pll_ff_rst` mid-window while locked → all outputs 0 immediately. After release with ideal inputs, lock is reacquired after 4 full windows.

Source files
------------

// File: rtl/pll_mon_pkg.sv
// Shared types and widths for the FF-PLL lock monitor.
package pll_mon_pkg;

  localparam int unsigned UnlockCntW = 16;
  localparam int unsigned RunW       = 4;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAcq    = 2'd1,
    StLocked = 2'd2,
    StHold   = 2'd3
  } pll_mon_state_t;

endpackage

// File: rtl/pll_mon_sync.sv
// Two-flop bit synchronizer with asynchronous active-low reset.
module pll_mon_sync (
  input  logic clk_i,
  input  logic pll_ff_rst,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i or negedge pll_ff_rst) begin
    if (!pll_ff_rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/pll_lock_monitor.sv
// Integrates FF-PLL lock indications over fixed windows into a debounced lock status.
// Define PLL_LOCK_MON_IRQ_EN to build the sticky lock-change interrupt on irq_o.
module pll_lock_monitor
  import pll_mon_pkg::*;
#(
  parameter int unsigned WIN         = 125000,
  parameter int unsigned THR         = 87500,
  parameter int unsigned LOCK_WINS   = 4,
  parameter int unsigned UNLOCK_WINS = 2,
  localparam int unsigned W          = $clog2(WIN + 1)
) (
  input  logic                  clk_i,
  input  logic                  pll_ff_rst,
  input  logic                  pll_lo_i,
  input  logic                  pll_hi_i,
  input  logic                  ref_val_i,
  input  logic                  en_i,
  input  logic                  clr_i,
  output logic                  lock_o,
  output logic                  lock_chg_o,
  output logic [1:0]            state_o,
  output logic [W-1:0]          duty_lo_o,
  output logic [W-1:0]          duty_hi_o,
  output logic [UnlockCntW-1:0] unlock_cnt_o,
  output logic                  irq_o
);

  localparam int unsigned WcntW = (WIN > 1) ? $clog2(WIN) : 1;
  localparam logic [WcntW-1:0] WcntLast  = WcntW'(WIN - 1);
  localparam logic [W-1:0]     AccMax    = W'(WIN);
  localparam logic [W-1:0]     ThrVal    = W'(THR);
  localparam logic [RunW-1:0]  LockRun   = RunW'(LOCK_WINS);
  localparam logic [RunW-1:0]  UnlockRun = RunW'(UNLOCK_WINS);

  // Reset asserts asynchronously, releases two edges later.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk_i or negedge pll_ff_rst) begin
    if (!pll_ff_rst) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  logic lo_s, hi_s;

  pll_mon_sync u_sync_lo (
    .clk_i      (clk_i),
    .pll_ff_rst (rst_n),
    .d_i        (pll_lo_i),
    .q_o        (lo_s)
  );

  pll_mon_sync u_sync_hi (
    .clk_i      (clk_i),
    .pll_ff_rst (rst_n),
    .d_i        (pll_hi_i),
    .q_o        (hi_s)
  );

  pll_mon_state_t       state_q, state_d;
  logic [RunW-1:0]      run_q, run_d, run_inc;
  logic                 lock_q, lock_d, lock_chg_q;
  logic [UnlockCntW-1:0] unlock_cnt_q, unlock_cnt_d;

  logic [WcntW-1:0] wcnt_q;
  logic [W-1:0]     lo_acc_q, hi_acc_q, lo_acc_nxt, hi_acc_nxt;
  logic [W-1:0]     duty_lo_q, duty_hi_q;
  logic             ref_ok_q;
  logic             active, win_end, good;

  // Window totals include the sample of the current cycle.
  always_comb begin
    active     = (state_q != StIdle);
    win_end    = active && (wcnt_q == WcntLast);
    lo_acc_nxt = lo_acc_q;
    hi_acc_nxt = hi_acc_q;
    if (lo_s && (lo_acc_q != AccMax)) lo_acc_nxt = lo_acc_q + W'(1);
    if (!hi_s && (hi_acc_q != AccMax)) hi_acc_nxt = hi_acc_q + W'(1);
    good = (lo_acc_nxt > ThrVal) && (hi_acc_nxt > ThrVal) && ref_ok_q && ref_val_i;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_q    <= '0;
      lo_acc_q  <= '0;
      hi_acc_q  <= '0;
      ref_ok_q  <= 1'b1;
      duty_lo_q <= '0;
      duty_hi_q <= '0;
    end else begin
      if (win_end) begin
        duty_lo_q <= lo_acc_nxt;
        duty_hi_q <= hi_acc_nxt;
      end
      if (!active || !en_i || win_end) begin
        wcnt_q   <= '0;
        lo_acc_q <= '0;
        hi_acc_q <= '0;
        ref_ok_q <= 1'b1;
      end else begin
        wcnt_q   <= wcnt_q + WcntW'(1);
        lo_acc_q <= lo_acc_nxt;
        hi_acc_q <= hi_acc_nxt;
        ref_ok_q <= ref_ok_q & ref_val_i;
      end
    end
  end

  assign run_inc = run_q + RunW'(1);

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    if (!en_i) begin
      state_d = StIdle;
      run_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StAcq;
          run_d   = '0;
        end
        StAcq: begin
          if (win_end) begin
            if (!good) begin
              run_d = '0;
            end else if (run_inc == LockRun) begin
              state_d = StLocked;
              run_d   = '0;
            end else begin
              run_d = run_inc;
            end
          end
        end
        StLocked: begin
          if (win_end && !good) begin
            if (UNLOCK_WINS == 1) begin
              state_d = StAcq;
              run_d   = '0;
            end else begin
              state_d = StHold;
              run_d   = RunW'(1);
            end
          end
        end
        StHold: begin
          if (win_end) begin
            if (good) begin
              state_d = StLocked;
              run_d   = '0;
            end else if (run_inc == UnlockRun) begin
              state_d = StAcq;
              run_d   = '0;
            end else begin
              run_d = run_inc;
            end
          end
        end
        default: begin
          state_d = StIdle;
          run_d   = '0;
        end
      endcase
    end
    lock_d = (state_d == StLocked) || (state_d == StHold);
    // Leaving {LOCKED, HOLD} is exactly a falling lock; clear beats increment.
    unlock_cnt_d = unlock_cnt_q;
    if (clr_i) begin
      unlock_cnt_d = '0;
    end else if (lock_q && !lock_d && !(&unlock_cnt_q)) begin
      unlock_cnt_d = unlock_cnt_q + UnlockCntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      run_q        <= '0;
      lock_q       <= 1'b0;
      lock_chg_q   <= 1'b0;
      unlock_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      run_q        <= run_d;
      lock_q       <= lock_d;
      lock_chg_q   <= lock_d ^ lock_q;
      unlock_cnt_q <= unlock_cnt_d;
    end
  end

`ifdef PLL_LOCK_MON_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      irq_q <= 1'b0;
    end else if (lock_d ^ lock_q) begin
      irq_q <= 1'b1;
    end else if (clr_i) begin
      irq_q <= 1'b0;
    end
  end

  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

  assign lock_o       = lock_q;
  assign lock_chg_o   = lock_chg_q;
  assign state_o      = state_q;
  assign duty_lo_o    = duty_lo_q;
  assign duty_hi_o    = duty_hi_q;
  assign unlock_cnt_o = unlock_cnt_q;

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Self-checking bench for pll_lock_monitor: directed scenarios plus randomized windows,
// every cycle compared against a window-level reference model.
module tb_pll_lock_monitor;

  localparam int WIN         = 100;
  localparam int THR         = 70;
  localparam int LOCK_WINS   = 4;
  localparam int UNLOCK_WINS = 2;
  localparam int W           = $clog2(WIN + 1);
  localparam int VW          = 5 + 16 + 2 * W;

  logic          clk_i = 1'b0;
  logic          pll_ff_rst = 1'b0;
  logic          pll_lo_i = 1'b0;
  logic          pll_hi_i = 1'b1;
  logic          ref_val_i = 1'b0;
  logic          en_i = 1'b0;
  logic          clr_i = 1'b0;
  logic          lock_o, lock_chg_o, irq_o;
  logic [1:0]    state_o;
  logic [W-1:0]  duty_lo_o, duty_hi_o;
  logic [15:0]   unlock_cnt_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  pll_lock_monitor #(
    .WIN         (WIN),
    .THR         (THR),
    .LOCK_WINS   (LOCK_WINS),
    .UNLOCK_WINS (UNLOCK_WINS)
  ) dut (
    .clk_i        (clk_i),
    .pll_ff_rst   (pll_ff_rst),
    .pll_lo_i     (pll_lo_i),
    .pll_hi_i     (pll_hi_i),
    .ref_val_i    (ref_val_i),
    .en_i         (en_i),
    .clr_i        (clr_i),
    .lock_o       (lock_o),
    .lock_chg_o   (lock_chg_o),
    .state_o      (state_o),
    .duty_lo_o    (duty_lo_o),
    .duty_hi_o    (duty_hi_o),
    .unlock_cnt_o (unlock_cnt_o),
    .irq_o        (irq_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: windows of WIN samples, streaks of good/bad windows.
  int m_hold, pos, lo_sum, hi_sum, good_run, bad_run, m_ucnt, m_dlo, m_dhi;
  bit lo1, lo2, hi1, hi2, ref_all, m_active, m_locked, m_chg, m_irq;

  task automatic model_reset();
    m_hold = 2; pos = 0; lo_sum = 0; hi_sum = 0; good_run = 0; bad_run = 0;
    m_ucnt = 0; m_dlo = 0; m_dhi = 0; lo1 = 0; lo2 = 0; hi1 = 0; hi2 = 0;
    ref_all = 1; m_active = 0; m_locked = 0; m_chg = 0; m_irq = 0;
  endtask

  task automatic model_step();
    bit lo_s, hi_s, end_win, good, was, unl;
    int lo_t, hi_t;
    if (!pll_ff_rst) begin
      model_reset();
      return;
    end
    if (m_hold > 0) begin
      m_hold--;
      return;
    end
    lo_s = lo2; hi_s = hi2;
    lo2 = lo1; lo1 = pll_lo_i; hi2 = hi1; hi1 = pll_hi_i;
    end_win = m_active && (pos == WIN - 1);
    lo_t = lo_sum + (lo_s ? 1 : 0);
    hi_t = hi_sum + (hi_s ? 0 : 1);
    good = (lo_t > THR) && (hi_t > THR) && ref_all && ref_val_i;
    was = m_locked;
    unl = 0;
    if (end_win) begin
      m_dlo = lo_t;
      m_dhi = hi_t;
    end
    if (!m_active || !en_i || end_win) begin
      pos = 0; lo_sum = 0; hi_sum = 0; ref_all = 1;
    end else begin
      pos++; lo_sum = lo_t; hi_sum = hi_t; ref_all = ref_all && ref_val_i;
    end
    if (!en_i) begin
      unl = m_locked; m_active = 0; m_locked = 0; good_run = 0; bad_run = 0;
    end else if (!m_active) begin
      m_active = 1;
    end else if (end_win) begin
      if (!m_locked) begin
        good_run = good ? good_run + 1 : 0;
        if (good_run == LOCK_WINS) begin
          m_locked = 1;
          good_run = 0;
        end
      end else begin
        bad_run = good ? 0 : bad_run + 1;
        if (bad_run == UNLOCK_WINS) begin
          m_locked = 0;
          bad_run = 0;
          unl = 1;
        end
      end
    end
    m_chg = (m_locked != was);
    if (clr_i) m_ucnt = 0;
    else if (unl && m_ucnt < 65535) m_ucnt++;
`ifdef PLL_LOCK_MON_IRQ_EN
    if (m_chg) m_irq = 1;
    else if (clr_i) m_irq = 0;
`endif
  endtask

  function automatic logic [VW-1:0] exp_vec();
    int st;
    st = !m_active ? 0 : (!m_locked ? 1 : (bad_run > 0 ? 3 : 2));
    return {2'(st), m_locked, m_chg, m_irq, 16'(m_ucnt), W'(m_dlo), W'(m_dhi)};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {state_o, lock_o, lock_chg_o, irq_o, unlock_cnt_o, duty_lo_o, duty_hi_o};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    model_step();
    #1;
    check("outs", 64'(dut_vec()), 64'(exp_vec()));
    @(negedge clk_i);
  endtask

  task automatic set_ideal();
    pll_lo_i = 1'b1; pll_hi_i = 1'b0; ref_val_i = 1'b1;
  endtask

  // Period-WIN lo pattern with 70 ones; last two entries high so a window
  // straddling the synchronizer delay also sees exactly 70.
  bit pat[WIN];

  task automatic build_pattern();
    int ones;
    for (int i = 0; i < WIN; i++) pat[i] = 0;
    pat[WIN - 1] = 1;
    pat[WIN - 2] = 1;
    ones = 2;
    while (ones < THR) begin
      int k;
      k = $urandom_range(0, WIN - 3);
      if (!pat[k]) begin
        pat[k] = 1;
        ones++;
      end
    end
  endtask

  task automatic run_pattern(input int n);
    for (int i = 0; i < n; i++) begin
      pll_lo_i = pat[i % WIN];
      tick();
    end
    set_ideal();
  endtask

  initial begin
    int n, pulses, bad;
    model_reset();
    build_pattern();
    repeat (3) tick();
    check("reset_state", 64'(dut_vec()), 64'd0);
    pll_ff_rst = 1'b1;
    set_ideal();
    repeat (5) tick();

    // Ideal inputs: lock after LOCK_WINS windows.
    en_i = 1'b1;
    n = 0;
    pulses = 0;
    while (!lock_o && n < 1000) begin
      tick();
      n++;
      if (lock_chg_o) pulses++;
    end
    tick();
    if (lock_chg_o) pulses++;
    check("lock_latency", 64'(n), 64'd401);
    check("lock_chg_pulses", 64'(pulses), 64'd1);
    check("duty_lo_ideal", 64'(duty_lo_o), 64'd100);
    check("duty_hi_ideal", 64'(duty_hi_o), 64'd100);
    repeat (WIN - 1) tick();

    // Two marginal windows (lo=70, not > THR): HOLD then ACQ.
    run_pattern(WIN);
    check("hold_state", 64'(state_o), 64'd3);
    check("hold_lock", 64'(lock_o), 64'd1);
    run_pattern(WIN);
    check("unlock_state", 64'(state_o), 64'd1);
    check("unlock_lock", 64'(lock_o), 64'd0);
    check("unlock_cnt_1", 64'(unlock_cnt_o), 64'd1);
    check("duty_lo_70", 64'(duty_lo_o), 64'd70);

    // Relock, then bad window + good window: stays locked.
    repeat (4 * WIN) tick();
    check("relock", 64'(lock_o), 64'd1);
    pulses = 0;
    for (int i = 0; i < WIN; i++) begin
      pll_lo_i = pat[i];
      tick();
      if (lock_chg_o) pulses++;
    end
    set_ideal();
    check("bad_then_hold", 64'(state_o), 64'd3);
    for (int i = 0; i < WIN; i++) begin
      tick();
      if (lock_chg_o) pulses++;
    end
    check("good_back_locked", 64'(state_o), 64'd2);
    check("no_chg_in_hold", 64'(pulses), 64'd0);
    check("unlock_cnt_kept", 64'(unlock_cnt_o), 64'd1);

    // One-cycle ref_val drop per window: unlocks and never relocks.
    bad = 0;
    for (int i = 0; i < 6 * WIN; i++) begin
      ref_val_i = (i % WIN) != 50;
      tick();
      if (i >= 3 * WIN && state_o != 2'd1) bad++;
    end
    set_ideal();
    check("ref_drop_acq", 64'(bad), 64'd0);
    check("ref_drop_unlock_cnt", 64'(unlock_cnt_o), 64'd2);

    // clr_i coincident with the unlocking window end.
    repeat (4 * WIN) tick();
    check("relock2", 64'(lock_o), 64'd1);
    for (int i = 0; i < 2 * WIN; i++) begin
      pll_lo_i = pat[i % WIN];
      clr_i = (i == 2 * WIN - 1);
      tick();
    end
    clr_i = 1'b0;
    set_ideal();
    check("clr_wins_cnt", 64'(unlock_cnt_o), 64'd0);
    check("clr_state", 64'(state_o), 64'd1);
`ifdef PLL_LOCK_MON_IRQ_EN
    check("irq_after_clr", 64'(irq_o), 64'd1);
`else
    check("irq_tied_low", 64'(irq_o), 64'd0);
`endif

    // Reset mid-window while locked, then reacquire.
    repeat (4 * WIN + 37) tick();
    check("locked_before_rst", 64'(lock_o), 64'd1);
    #2;
    pll_ff_rst = 1'b0;
    #1;
    check("async_rst_outs", 64'(dut_vec()), 64'd0);
    model_reset();
    repeat (3) tick();
    pll_ff_rst = 1'b1;
    n = 0;
    while (!lock_o && n < 1000) begin
      tick();
      n++;
    end
    check("relock_after_rst", 64'(n), 64'd403);

    // Randomized windows against the model.
    for (int w = 0; w < 40; w++) begin
      int mode;
      mode = $urandom_range(0, 4);
      for (int c = 0; c < WIN; c++) begin
        pll_lo_i  = (mode == 1) ? ($urandom_range(0, 99) < 72) :
                    (mode == 2) ? ($urandom_range(0, 99) < 60) : 1'b1;
        pll_hi_i  = (mode == 3) ? ($urandom_range(0, 99) < 35) : ($urandom_range(0, 99) < 2);
        ref_val_i = (mode != 4) || ($urandom_range(0, 49) != 0);
        clr_i     = ($urandom_range(0, 299) == 0);
        en_i      = !(($urandom_range(0, 1999) == 0) ||
                      (w % 10 == 9 && m_active && pos == WIN - 1));
        tick();
      end
    end
    clr_i = 1'b0;
    en_i  = 1'b1;
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
